gen_reg_file: RTL and testbench

Parametrised general-purpose register file, the successor to the fixed 8x8 register bank.
- NREG registers of WIDTH bits each, written from a narrower LANE-bit data bus, one lane per cycle.
- Per-register function select: clear, lane load, decrement, increment.
- Optional saturation, with a sticky overflow flag per register.
- Two independent combinational read ports with zero flags; feeds the ALU operand muxes and address datapath.

---
 rtl/gen_reg_pkg.sv | 17 +
 rtl/gen_reg_file_if.sv | 37 +++
 rtl/gen_reg.sv | 72 +++++++
 rtl/gen_reg_file.sv | 54 +++++
 tb/tb_gen_reg_file.sv | 136 +++++++++++++
 5 files changed

// File: rtl/gen_reg_pkg.sv
// Shared definitions for the general-purpose register file.
// Exports the function-select encoding and the lane-index width helper.
package gen_reg_pkg;

  typedef enum logic [1:0] {
    FS_CLR  = 2'b00,
    FS_LOAD = 2'b01,
    FS_DEC  = 2'b10,
    FS_INC  = 2'b11
  } funsel_e;

  // Lane index width; at least one bit, even when a register is a single lane.
  function automatic int unsigned lane_sel_w(input int unsigned width, input int unsigned lane);
    return ((width / lane) > 1) ? $clog2(width / lane) : 1;
  endfunction

endpackage

// File: rtl/gen_reg_file_if.sv
// Write/read bus of the register file.
// Inputs to the file: load, lane_sel, funsel, rsel, o1sel, o2sel.
// Outputs from the file: o1, o2, zero1, zero2, ovf.
// master = the side that issues operations, slave = the register file.
interface gen_reg_file_if #(
  parameter int unsigned NREG  = 8,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 8
);
  import gen_reg_pkg::*;

  localparam int unsigned LSW = lane_sel_w(WIDTH, LANE);
  localparam int unsigned SW  = $clog2(NREG);

  logic [LANE-1:0]  load;
  logic [LSW-1:0]   lane_sel;
  funsel_e          funsel;
  logic [NREG-1:0]  rsel;
  logic [SW-1:0]    o1sel;
  logic [SW-1:0]    o2sel;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic             zero1;
  logic             zero2;
  logic [NREG-1:0]  ovf;

  modport master (
    output load, lane_sel, funsel, rsel, o1sel, o2sel,
    input  o1, o2, zero1, zero2, ovf
  );

  modport slave (
    input  load, lane_sel, funsel, rsel, o1sel, o2sel,
    output o1, o2, zero1, zero2, ovf
  );

endinterface

// File: rtl/gen_reg.sv
// Single register of the file: clear, lane load, decrement, increment,
// optional saturation, sticky overflow flag.
// Ports: clk, rst (sync, active-high), en, funsel, lane_sel, load -> q, ovf.
module gen_reg
  import gen_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 8,
  parameter int unsigned SAT   = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  funsel_e                               funsel,
  input  logic [lane_sel_w(WIDTH, LANE)-1:0]    lane_sel,
  input  logic [LANE-1:0]                       load,
  output logic [WIDTH-1:0]                      q,
  output logic                                  ovf
);

  localparam int unsigned NLANE = WIDTH / LANE;
  localparam int unsigned LSW   = lane_sel_w(WIDTH, LANE);

  logic [WIDTH-1:0] q_nxt;
  logic             ovf_nxt;

  // Next value; an out-of-range lane index matches no lane and writes nothing.
  always_comb begin
    q_nxt   = q;
    ovf_nxt = ovf;
    unique case (funsel)
      FS_CLR: begin
        q_nxt   = '0;
        ovf_nxt = 1'b0;
      end
      FS_LOAD: begin
        for (int unsigned l = 0; l < NLANE; l++) begin
          if (NLANE == 1 || lane_sel == LSW'(l)) q_nxt[l*LANE +: LANE] = load;
        end
      end
      FS_INC: begin
        if (q == '1) begin
          ovf_nxt = 1'b1;
          q_nxt   = (SAT != 0) ? q : '0;
        end else begin
          q_nxt = q + WIDTH'(1);
        end
      end
      FS_DEC: begin
        if (q == '0) begin
          ovf_nxt = 1'b1;
          q_nxt   = (SAT != 0) ? q : '1;
        end else begin
          q_nxt = q - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // State register; reset wins over any enabled operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      q   <= q_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: rtl/gen_reg_file.sv
// Parametrised general-purpose register file: NREG x WIDTH registers loaded
// one LANE-bit lane per cycle, inc/dec with optional saturation, sticky
// per-register overflow, two combinational read ports with zero flags.
// Ports: clk, rst (sync, active-high), bus (gen_reg_file_if.slave).
module gen_reg_file
  import gen_reg_pkg::*;
#(
  parameter int unsigned NREG  = 8,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 8,
  parameter int unsigned SAT   = 0
) (
  input  logic           clk,
  input  logic           rst,
  gen_reg_file_if.slave  bus
);

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  ovf_vec;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    gen_reg #(
      .WIDTH (WIDTH),
      .LANE  (LANE),
      .SAT   (SAT)
    ) u_reg (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.rsel[i]),
      .funsel   (bus.funsel),
      .lane_sel (bus.lane_sel),
      .load     (bus.load),
      .q        (regs[i]),
      .ovf      (ovf_vec[i])
    );
  end

  // Read ports: indices past the last register read as zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (32'(bus.o1sel) < NREG) rd1 = regs[bus.o1sel];
    if (32'(bus.o2sel) < NREG) rd2 = regs[bus.o2sel];
  end

  assign bus.o1    = rd1;
  assign bus.o2    = rd2;
  assign bus.zero1 = (rd1 == '0);
  assign bus.zero2 = (rd2 == '0);
  assign bus.ovf   = ovf_vec;

endmodule

// File: tb/tb_gen_reg_file.sv
// Bench for gen_reg_file: a wrapping and a saturating 8x16 instance share one
// directed vector table; a 6x24 instance covers out-of-range lane and read index.
module tb_gen_reg_file;
  import gen_reg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gen_reg_file_if #(.NREG(8), .WIDTH(16), .LANE(8)) b0 ();
  gen_reg_file_if #(.NREG(8), .WIDTH(16), .LANE(8)) b1 ();
  gen_reg_file_if #(.NREG(6), .WIDTH(24), .LANE(8)) b2 ();

  gen_reg_file #(.NREG(8), .WIDTH(16), .LANE(8), .SAT(0)) d0 (.clk(clk), .rst(rst), .bus(b0.slave));
  gen_reg_file #(.NREG(8), .WIDTH(16), .LANE(8), .SAT(1)) d1 (.clk(clk), .rst(rst), .bus(b1.slave));
  gen_reg_file #(.NREG(6), .WIDTH(24), .LANE(8), .SAT(0)) d2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // e1/e2/eo: wrapping instance; e1s/e2s/eos: saturating instance.
  typedef struct {
    logic        r;
    logic [7:0]  rsel;
    funsel_e     fs;
    logic        ls;
    logic [7:0]  ld;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [7:0]  eo;
    logic [15:0] e1s;
    logic [15:0] e2s;
    logic [7:0]  eos;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(logic r, logic [7:0] rsel, funsel_e fs, logic ls, logic [7:0] ld,
                              logic [2:0] s1, logic [2:0] s2,
                              logic [15:0] e1, logic [15:0] e2, logic [7:0] eo,
                              logic [15:0] e1s, logic [15:0] e2s, logic [7:0] eos);
    vec_t t;
    t.r = r; t.rsel = rsel; t.fs = fs; t.ls = ls; t.ld = ld; t.s1 = s1; t.s2 = s2;
    t.e1 = e1; t.e2 = e2; t.eo = eo; t.e1s = e1s; t.e2s = e2s; t.eos = eos;
    return t;
  endfunction

  task automatic drv2(input logic [5:0] rsel, input funsel_e fs, input logic [1:0] ls,
                      input logic [7:0] ld, input logic [2:0] s1, input logic [2:0] s2);
    b2.rsel = rsel; b2.funsel = fs; b2.lane_sel = ls; b2.load = ld;
    b2.o1sel = s1; b2.o2sel = s2;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    b0.rsel = '0; b0.funsel = FS_CLR; b0.lane_sel = '0; b0.load = '0; b0.o1sel = '0; b0.o2sel = '0;
    b1.rsel = '0; b1.funsel = FS_CLR; b1.lane_sel = '0; b1.load = '0; b1.o1sel = '0; b1.o2sel = '0;
    b2.rsel = '0; b2.funsel = FS_CLR; b2.lane_sel = '0; b2.load = '0; b2.o1sel = '0; b2.o2sel = '0;

    //            r  rsel   fs       ls ld     s1 s2  e1       e2       eo     e1s      e2s      eos
    v.push_back(mk(1, 8'hFF, FS_INC,  0, 8'h00, 0, 1, 16'h0000, 16'h0000, 8'h00, 16'h0000, 16'h0000, 8'h00));
    v.push_back(mk(0, 8'h01, FS_LOAD, 0, 8'h34, 0, 1, 16'h0034, 16'h0000, 8'h00, 16'h0034, 16'h0000, 8'h00));
    v.push_back(mk(0, 8'h01, FS_LOAD, 1, 8'h12, 0, 1, 16'h1234, 16'h0000, 8'h00, 16'h1234, 16'h0000, 8'h00));
    v.push_back(mk(0, 8'h04, FS_LOAD, 0, 8'hFF, 2, 0, 16'h00FF, 16'h1234, 8'h00, 16'h00FF, 16'h1234, 8'h00));
    v.push_back(mk(0, 8'h04, FS_LOAD, 1, 8'hFF, 2, 0, 16'hFFFF, 16'h1234, 8'h00, 16'hFFFF, 16'h1234, 8'h00));
    v.push_back(mk(0, 8'h04, FS_INC,  0, 8'h00, 2, 0, 16'h0000, 16'h1234, 8'h04, 16'hFFFF, 16'h1234, 8'h04));
    v.push_back(mk(0, 8'h08, FS_DEC,  0, 8'h00, 3, 2, 16'hFFFF, 16'h0000, 8'h0C, 16'h0000, 16'hFFFF, 8'h0C));
    v.push_back(mk(0, 8'h08, FS_CLR,  0, 8'h00, 3, 2, 16'h0000, 16'h0000, 8'h04, 16'h0000, 16'hFFFF, 8'h04));
    v.push_back(mk(0, 8'h08, FS_INC,  0, 8'h00, 3, 2, 16'h0001, 16'h0000, 8'h04, 16'h0001, 16'hFFFF, 8'h04));
    v.push_back(mk(0, 8'h01, FS_LOAD, 0, 8'hFF, 0, 7, 16'h12FF, 16'h0000, 8'h04, 16'h12FF, 16'h0000, 8'h04));
    v.push_back(mk(0, 8'h01, FS_LOAD, 1, 8'h00, 0, 7, 16'h00FF, 16'h0000, 8'h04, 16'h00FF, 16'h0000, 8'h04));
    v.push_back(mk(0, 8'h80, FS_LOAD, 0, 8'h10, 0, 7, 16'h00FF, 16'h0010, 8'h04, 16'h00FF, 16'h0010, 8'h04));
    v.push_back(mk(0, 8'h81, FS_INC,  0, 8'h00, 0, 7, 16'h0100, 16'h0011, 8'h04, 16'h0100, 16'h0011, 8'h04));
    v.push_back(mk(0, 8'h00, FS_INC,  0, 8'h00, 0, 7, 16'h0100, 16'h0011, 8'h04, 16'h0100, 16'h0011, 8'h04));
    v.push_back(mk(0, 8'h00, FS_LOAD, 0, 8'h00, 3, 3, 16'h0001, 16'h0001, 8'h04, 16'h0001, 16'h0001, 8'h04));
    v.push_back(mk(1, 8'hFF, FS_INC,  0, 8'h00, 0, 7, 16'h0000, 16'h0000, 8'h00, 16'h0000, 16'h0000, 8'h00));

    foreach (v[i]) begin
      rst = v[i].r;
      b0.rsel = v[i].rsel; b0.funsel = v[i].fs; b0.lane_sel = v[i].ls; b0.load = v[i].ld;
      b0.o1sel = v[i].s1;  b0.o2sel = v[i].s2;
      b1.rsel = v[i].rsel; b1.funsel = v[i].fs; b1.lane_sel = v[i].ls; b1.load = v[i].ld;
      b1.o1sel = v[i].s1;  b1.o2sel = v[i].s2;
      @(posedge clk); #1;
      chk($sformatf("v%0d wrap o1", i),    32'(b0.o1),    32'(v[i].e1));
      chk($sformatf("v%0d wrap o2", i),    32'(b0.o2),    32'(v[i].e2));
      chk($sformatf("v%0d wrap zero1", i), 32'(b0.zero1), 32'(v[i].e1 == 16'h0));
      chk($sformatf("v%0d wrap zero2", i), 32'(b0.zero2), 32'(v[i].e2 == 16'h0));
      chk($sformatf("v%0d wrap ovf", i),   32'(b0.ovf),   32'(v[i].eo));
      chk($sformatf("v%0d sat o1", i),     32'(b1.o1),    32'(v[i].e1s));
      chk($sformatf("v%0d sat o2", i),     32'(b1.o2),    32'(v[i].e2s));
      chk($sformatf("v%0d sat zero1", i),  32'(b1.zero1), 32'(v[i].e1s == 16'h0));
      chk($sformatf("v%0d sat zero2", i),  32'(b1.zero2), 32'(v[i].e2s == 16'h0));
      chk($sformatf("v%0d sat ovf", i),    32'(b1.ovf),   32'(v[i].eos));
    end
    rst = 1'b0;
    b0.rsel = '0; b1.rsel = '0;

    // 6x24 instance: three-lane load, unused lane index, out-of-range reads.
    drv2(6'h20, FS_LOAD, 2'd0, 8'hAA, 3'd5, 3'd7);
    chk("n6 lane0 o1", 32'(b2.o1), 32'h0000AA);
    chk("n6 oor o2", 32'(b2.o2), 32'h0);
    chk("n6 oor zero2", 32'(b2.zero2), 32'h1);
    drv2(6'h20, FS_LOAD, 2'd1, 8'hBB, 3'd5, 3'd7);
    chk("n6 lane1 o1", 32'(b2.o1), 32'h00BBAA);
    drv2(6'h20, FS_LOAD, 2'd2, 8'hCC, 3'd5, 3'd7);
    chk("n6 lane2 o1", 32'(b2.o1), 32'hCCBBAA);
    drv2(6'h20, FS_LOAD, 2'd3, 8'h11, 3'd5, 3'd7);
    chk("n6 bad lane o1", 32'(b2.o1), 32'hCCBBAA);
    drv2(6'h01, FS_INC, 2'd0, 8'h00, 3'd6, 3'd5);
    chk("n6 oor6 o1", 32'(b2.o1), 32'h0);
    chk("n6 oor6 zero1", 32'(b2.zero1), 32'h1);
    chk("n6 hold o2", 32'(b2.o2), 32'hCCBBAA);
    chk("n6 zero2 clear", 32'(b2.zero2), 32'h0);
    drv2(6'h00, FS_CLR, 2'd0, 8'h00, 3'd7, 3'd0);
    chk("n6 oor7 o1", 32'(b2.o1), 32'h0);
    chk("n6 oor7 zero1", 32'(b2.zero1), 32'h1);
    chk("n6 inc o2", 32'(b2.o2), 32'h000001);
    chk("n6 ovf", 32'(b2.ovf), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
